// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// memory_pkg / mem_access_unit
//
// Purpose: bridges a single-outstanding core load/store request onto the
// mem_read and mem_write external ports. Each access goes through the FSM
// IDLE -> ISSUE -> CAPTURE -> RESP. Alignment faults and illegal sizes skip
// the memory and go straight from IDLE to RESP.
//
// Handshake: a request transfers on the rising CLK edge where REQ_VALID and
// REQ_READY are both 1. REQ_READY is 1 only in IDLE, so REQ_VALID seen in any
// other state is ignored and not queued. RSP_VALID is a single-cycle pulse
// with no backpressure.
//
// Ports:
//   CLK, RSTn          block clock and synchronous active-low reset
//   REQ_*              core request: valid/ready, we, size, unsigned, addr, wdata
//   RSP_*              core response: valid pulse, extended read data, error
//   RD_*               mem_read ext_read_port (clock, enable, word, addr, data, err)
//   WR_*               mem_write ext_write_port (clock, enable, word, addr, data, err)
//   STATE_DBG          current FSM state (IDLE=0, ISSUE=1, CAPTURE=2, RESP=3)
// -----------------------------------------------------------------------------
package memory_pkg;
    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_WORD_WIDTH = 32;
endpackage

module mem_access_unit #(
    parameter int MEM_ADDR_WIDTH = memory_pkg::MEM_ADDR_WIDTH,
    parameter int MEM_WORD_WIDTH = memory_pkg::MEM_WORD_WIDTH
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    // core request
    input  logic                      REQ_VALID,
    output logic                      REQ_READY,
    input  logic                      REQ_WE,
    input  logic [1:0]                REQ_SIZE,
    input  logic                      REQ_UNSIGNED,
    input  logic [MEM_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [MEM_WORD_WIDTH-1:0] REQ_WDATA,
    // core response
    output logic                      RSP_VALID,
    output logic [MEM_WORD_WIDTH-1:0] RSP_RDATA,
    output logic                      RSP_ERR,
    // mem_read ext_read_port
    output logic                      RD_M_CLK,
    output logic                      RD_ENABLE,
    output logic [1:0]                RD_WORD,
    output logic [MEM_ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [MEM_WORD_WIDTH-1:0] RD_DATAIN,
    input  logic                      RD_ADDR_ERR,
    // mem_write ext_write_port
    output logic                      WR_M_CLK,
    output logic                      WR_ENABLE,
    output logic [1:0]                WR_WORD,
    output logic [MEM_ADDR_WIDTH-1:0] WR_ADDR,
    output logic [MEM_WORD_WIDTH-1:0] WR_DATAOUT,
    input  logic                      WR_ADDR_ERR,
    // debug
    output logic [1:0]                STATE_DBG
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e state_q, state_d;

    logic                      we_q;
    logic [1:0]                size_q;
    logic                      uns_q;
    logic                      err_q;
    logic [MEM_WORD_WIDTH-1:0] rdata_q;
    logic [MEM_ADDR_WIDTH-1:0] rd_addr_q;
    logic [1:0]                rd_word_q;
    logic [MEM_ADDR_WIDTH-1:0] wr_addr_q;
    logic [1:0]                wr_word_q;
    logic [MEM_WORD_WIDTH-1:0] wr_data_q;

    logic                      accept;
    logic                      req_fault;
    logic [MEM_WORD_WIDTH-1:0] wdata_masked;
    logic [MEM_WORD_WIDTH-1:0] load_ext;

    assign accept = (state_q == ST_IDLE) && REQ_VALID;

    // Faults are decided from the live request so a bad access never
    // reaches either memory port.
    assign req_fault = (REQ_SIZE == 2'b11)
                    || ((REQ_SIZE == SZ_HALF) && REQ_ADDR[0])
                    || ((REQ_SIZE == SZ_WORD) && (REQ_ADDR[1:0] != 2'b00));

    // Store data is right-justified; clear everything above the access size.
    always_comb begin
        wdata_masked = REQ_WDATA;
        case (REQ_SIZE)
            SZ_BYTE: wdata_masked = {{(MEM_WORD_WIDTH-8){1'b0}},  REQ_WDATA[7:0]};
            SZ_HALF: wdata_masked = {{(MEM_WORD_WIDTH-16){1'b0}}, REQ_WDATA[15:0]};
            default: wdata_masked = REQ_WDATA;
        endcase
    end

    // Sign bit is bit 7 (byte) or bit 15 (half) of the sampled data; it is
    // forced to zero for unsigned loads.
    always_comb begin
        load_ext = RD_DATAIN;
        case (size_q)
            SZ_BYTE: load_ext = {{(MEM_WORD_WIDTH-8){RD_DATAIN[7] & ~uns_q}},
                                 RD_DATAIN[7:0]};
            SZ_HALF: load_ext = {{(MEM_WORD_WIDTH-16){RD_DATAIN[15] & ~uns_q}},
                                 RD_DATAIN[15:0]};
            default: load_ext = RD_DATAIN;
        endcase
    end

    // FSM state register
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_d = req_fault ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Request registers and port-side holding registers. The port registers
    // are only loaded by the port that will be used, so the idle port keeps
    // presenting its previous address/word/data.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            rd_addr_q <= '0;
            rd_word_q <= 2'b00;
            wr_addr_q <= '0;
            wr_word_q <= 2'b00;
            wr_data_q <= '0;
        end else begin
            if (accept) begin
                we_q   <= REQ_WE;
                size_q <= REQ_SIZE;
                uns_q  <= REQ_UNSIGNED;
                err_q  <= req_fault;
                rdata_q <= '0;
                if (!req_fault) begin
                    if (REQ_WE) begin
                        wr_addr_q <= REQ_ADDR;
                        wr_word_q <= REQ_SIZE;
                        wr_data_q <= wdata_masked;
                    end else begin
                        rd_addr_q <= REQ_ADDR;
                        rd_word_q <= REQ_SIZE;
                    end
                end
            end
            if (state_q == ST_CAPTURE) begin
                if (we_q) begin
                    err_q   <= WR_ADDR_ERR;
                    rdata_q <= '0;
                end else begin
                    err_q   <= RD_ADDR_ERR;
                    rdata_q <= RD_ADDR_ERR ? '0 : load_ext;
                end
            end
        end
    end

    assign RD_M_CLK   = CLK;
    assign WR_M_CLK   = CLK;

    assign REQ_READY  = (state_q == ST_IDLE);

    assign RD_ENABLE  = (state_q == ST_ISSUE) && !we_q;
    assign WR_ENABLE  = (state_q == ST_ISSUE) &&  we_q;
    assign RD_ADDR    = rd_addr_q;
    assign RD_WORD    = rd_word_q;
    assign WR_ADDR    = wr_addr_q;
    assign WR_WORD    = wr_word_q;
    assign WR_DATAOUT = wr_data_q;

    // Response fields are only meaningful during the RESP pulse and read as
    // zero at every other time.
    assign RSP_VALID  = (state_q == ST_RESP);
    assign RSP_ERR    = (state_q == ST_RESP) && err_q;
    assign RSP_RDATA  = (state_q == ST_RESP) ? rdata_q : '0;

    assign STATE_DBG  = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Self-checking bench for mem_access_unit. The driver computes the expected
// response of every request from a small reference model and pushes it onto
// the scoreboard queues; a negedge monitor pops and compares each RSP_VALID
// pulse, including the cycle it arrives in. Port-side values are checked by
// the driver in the ISSUE cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int W  = 32;

    // ---------------- clock / reset ----------------
    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned   cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic          REQ_VALID = 1'b0;
    logic          REQ_READY;
    logic          REQ_WE = 1'b0;
    logic [1:0]    REQ_SIZE = 2'b00;
    logic          REQ_UNSIGNED = 1'b0;
    logic [AW-1:0] REQ_ADDR = '0;
    logic [W-1:0]  REQ_WDATA = '0;
    logic          RSP_VALID;
    logic [W-1:0]  RSP_RDATA;
    logic          RSP_ERR;
    logic          RD_M_CLK, RD_ENABLE;
    logic [1:0]    RD_WORD;
    logic [AW-1:0] RD_ADDR;
    logic [W-1:0]  RD_DATAIN = '0;
    logic          RD_ADDR_ERR = 1'b0;
    logic          WR_M_CLK, WR_ENABLE;
    logic [1:0]    WR_WORD;
    logic [AW-1:0] WR_ADDR;
    logic [W-1:0]  WR_DATAOUT;
    logic          WR_ADDR_ERR = 1'b0;
    logic [1:0]    STATE_DBG;

    mem_access_unit #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_WORD_WIDTH (W)
    ) dut (
        .CLK          (CLK),
        .RSTn         (RSTn),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_WE       (REQ_WE),
        .REQ_SIZE     (REQ_SIZE),
        .REQ_UNSIGNED (REQ_UNSIGNED),
        .REQ_ADDR     (REQ_ADDR),
        .REQ_WDATA    (REQ_WDATA),
        .RSP_VALID    (RSP_VALID),
        .RSP_RDATA    (RSP_RDATA),
        .RSP_ERR      (RSP_ERR),
        .RD_M_CLK     (RD_M_CLK),
        .RD_ENABLE    (RD_ENABLE),
        .RD_WORD      (RD_WORD),
        .RD_ADDR      (RD_ADDR),
        .RD_DATAIN    (RD_DATAIN),
        .RD_ADDR_ERR  (RD_ADDR_ERR),
        .WR_M_CLK     (WR_M_CLK),
        .WR_ENABLE    (WR_ENABLE),
        .WR_WORD      (WR_WORD),
        .WR_ADDR      (WR_ADDR),
        .WR_DATAOUT   (WR_DATAOUT),
        .WR_ADDR_ERR  (WR_ADDR_ERR),
        .STATE_DBG    (STATE_DBG)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fails  = 0;

    task automatic check_eq(input string tag, input logic [63:0] act,
                            input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
                     tag, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         exp_err_q[$];
    int unsigned  exp_cyc_q[$];

    always @(negedge CLK) begin
        if (RSP_VALID) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", {63'd0, RSP_VALID}, 64'd0);
            end else begin
                check_eq("rsp_rdata", {32'd0, RSP_RDATA}, {32'd0, exp_q.pop_front()});
                check_eq("rsp_err",   {63'd0, RSP_ERR},   {63'd0, exp_err_q.pop_front()});
                check_eq("rsp_cycle", {32'd0, cyc},       {32'd0, exp_cyc_q.pop_front()});
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] model_ext(input logic [W-1:0] d,
                                               input logic [1:0] sz,
                                               input logic uns);
        case (sz)
            2'b00:   return uns ? {24'd0, d[7:0]}  : {{24{d[7]}}, d[7:0]};
            2'b01:   return uns ? {16'd0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [W-1:0] model_mask(input logic [W-1:0] d,
                                                input logic [1:0] sz);
        case (sz)
            2'b00:   return d & 32'h0000_00FF;
            2'b01:   return d & 32'h0000_FFFF;
            default: return d;
        endcase
    endfunction

    // ---------------- driver ----------------
    // Entered and left at a negedge with the DUT in IDLE.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd_data, input logic rd_err,
                          input logic wr_err);
        logic         fault;
        logic [W-1:0] e_data;
        logic         e_err;
        int           n;

        n = 0;
        while (!REQ_READY && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("ready_before_req", {63'd0, REQ_READY}, 64'd1);

        fault = (sz == 2'b11) || (sz == 2'b01 && addr[0]) ||
                (sz == 2'b10 && addr[1:0] != 2'b00);
        if (fault) begin
            e_err = 1'b1; e_data = '0;
        end else if (we) begin
            e_err = wr_err; e_data = '0;
        end else begin
            e_err = rd_err; e_data = rd_err ? '0 : model_ext(rd_data, sz, uns);
        end
        exp_q.push_back(e_data);
        exp_err_q.push_back(e_err);
        exp_cyc_q.push_back(cyc + (fault ? 1 : 3));

        RD_DATAIN    = rd_data;
        RD_ADDR_ERR  = rd_err;
        WR_ADDR_ERR  = wr_err;
        REQ_WE       = we;
        REQ_SIZE     = sz;
        REQ_UNSIGNED = uns;
        REQ_ADDR     = addr;
        REQ_WDATA    = wdata;
        REQ_VALID    = 1'b1;
        @(negedge CLK);
        REQ_VALID    = 1'b0;

        if (fault) begin
            check_eq("fault_rd_en", {63'd0, RD_ENABLE}, 64'd0);
            check_eq("fault_wr_en", {63'd0, WR_ENABLE}, 64'd0);
        end else if (we) begin
            check_eq("st_wr_en",   {63'd0, WR_ENABLE}, 64'd1);
            check_eq("st_rd_en",   {63'd0, RD_ENABLE}, 64'd0);
            check_eq("st_wr_addr", {32'd0, WR_ADDR},   {32'd0, addr});
            check_eq("st_wr_word", {62'd0, WR_WORD},   {62'd0, sz});
            check_eq("st_wr_data", {32'd0, WR_DATAOUT}, {32'd0, model_mask(wdata, sz)});
        end else begin
            check_eq("ld_rd_en",   {63'd0, RD_ENABLE}, 64'd1);
            check_eq("ld_wr_en",   {63'd0, WR_ENABLE}, 64'd0);
            check_eq("ld_rd_addr", {32'd0, RD_ADDR},   {32'd0, addr});
            check_eq("ld_rd_word", {62'd0, RD_WORD},   {62'd0, sz});
        end

        n = 0;
        while (!REQ_READY && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check_eq("ready_after_rsp", {63'd0, REQ_READY}, 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"},    {63'd0, REQ_READY},  64'd1);
        check_eq({tag, "_rsp_v"},    {63'd0, RSP_VALID},  64'd0);
        check_eq({tag, "_rsp_err"},  {63'd0, RSP_ERR},    64'd0);
        check_eq({tag, "_rsp_data"}, {32'd0, RSP_RDATA},  64'd0);
        check_eq({tag, "_rd_en"},    {63'd0, RD_ENABLE},  64'd0);
        check_eq({tag, "_wr_en"},    {63'd0, WR_ENABLE},  64'd0);
        check_eq({tag, "_rd_addr"},  {32'd0, RD_ADDR},    64'd0);
        check_eq({tag, "_wr_addr"},  {32'd0, WR_ADDR},    64'd0);
        check_eq({tag, "_rd_word"},  {62'd0, RD_WORD},    64'd0);
        check_eq({tag, "_wr_word"},  {62'd0, WR_WORD},    64'd0);
        check_eq({tag, "_wr_data"},  {32'd0, WR_DATAOUT}, 64'd0);
        check_eq({tag, "_state"},    {62'd0, STATE_DBG},  64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;

        RSTn = 1'b0;
        repeat (3) @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check_reset_outputs("reset");
        check_eq("m_clk_rd", {63'd0, RD_M_CLK}, {63'd0, CLK});
        check_eq("m_clk_wr", {63'd0, WR_M_CLK}, {63'd0, CLK});

        // Directed cases
        do_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h0000_0080, 1'b0, 1'b0);
        do_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h1234_8001, 1'b0, 1'b0);
        do_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 32'h1234_8001, 1'b0, 1'b0);
        do_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00F0, 1'b0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b0);
        do_req(1'b1, 2'b00, 1'b0, 32'h05, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        // Load port must still hold the word load's address and size.
        check_eq("rd_addr_hold", {32'd0, RD_ADDR}, 64'h40);
        check_eq("rd_word_hold", {62'd0, RD_WORD}, 64'd2);
        check_eq("wr_addr_hold", {32'd0, WR_ADDR}, 64'h05);
        check_eq("wr_data_hold", {32'd0, WR_DATAOUT}, 64'hEF);
        do_req(1'b1, 2'b01, 1'b0, 32'h06, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0);
        do_req(1'b1, 2'b10, 1'b0, 32'h08, 32'h1234_5678, 32'h0, 1'b0, 1'b1);
        do_req(1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_req(1'b0, 2'b11, 1'b0, 32'h00, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_req(1'b1, 2'b01, 1'b0, 32'h01, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        do_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h1111_2222, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 30; i++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)),
                   $urandom, $urandom,
                   ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
        end

        // REQ_VALID held through ISSUE/CAPTURE/RESP must not start a second access.
        exp_q.push_back(32'hFFFF_FF80);
        exp_err_q.push_back(1'b0);
        exp_cyc_q.push_back(cyc + 3);
        RD_DATAIN = 32'h0000_0080; RD_ADDR_ERR = 1'b0;
        REQ_WE = 1'b0; REQ_SIZE = 2'b00; REQ_UNSIGNED = 1'b0; REQ_ADDR = 32'h13;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        check_eq("hold_ready_issue", {63'd0, REQ_READY}, 64'd0);
        @(negedge CLK);
        check_eq("hold_ready_capture", {63'd0, REQ_READY}, 64'd0);
        check_eq("hold_rd_en_capture", {63'd0, RD_ENABLE}, 64'd0);
        @(negedge CLK);
        check_eq("hold_ready_resp", {63'd0, REQ_READY}, 64'd0);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check_eq("hold_idle_ready", {63'd0, REQ_READY}, 64'd1);
        @(negedge CLK);
        check_eq("hold_no_reissue", {63'd0, RD_ENABLE}, 64'd0);
        check_eq("hold_state_idle", {62'd0, STATE_DBG}, 64'd0);

        // Reset during CAPTURE drops the access with no response.
        REQ_WE = 1'b0; REQ_SIZE = 2'b10; REQ_ADDR = 32'h40; RD_DATAIN = 32'h5555_AAAA;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        @(negedge CLK);
        check_eq("rstcap_state", {62'd0, STATE_DBG}, 64'd2);
        RSTn = 1'b0;
        @(negedge CLK);
        check_reset_outputs("rstcap");
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);
        check_eq("rstcap_ready_after", {63'd0, REQ_READY}, 64'd1);
        check_eq("rstcap_no_rsp", {63'd0, RSP_VALID}, 64'd0);

        // Reset during ISSUE clears the enable from the next cycle.
        REQ_WE = 1'b1; REQ_SIZE = 2'b10; REQ_ADDR = 32'h80; REQ_WDATA = 32'hA5A5_5A5A;
        REQ_VALID = 1'b1;
        @(negedge CLK);
        REQ_VALID = 1'b0;
        check_eq("rstiss_wr_en", {63'd0, WR_ENABLE}, 64'd1);
        RSTn = 1'b0;
        @(negedge CLK);
        check_reset_outputs("rstiss");
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        // Drain and report
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, default from memory_pkg: byte-address width of the memory ports.
REQ-002 Parameter MEM_WORD_WIDTH, default from memory_pkg (32): data width.
REQ-003 CLK  in  1: single block clock; rising edge active.
REQ-004 RSTn  in  1: synchronous reset, active-low, sampled on the rising edge of CLK.
REQ-005 REQ_VALID  in  1: core request valid.
REQ-006 REQ_READY  out  1: unit can accept a request.
REQ-007 REQ_WE  in  1: 1 = store, 0 = load.
REQ-008 REQ_SIZE  in  2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 REQ_UNSIGNED  in  1: load zero-extends when 1; sign-extends when 0.
REQ-010 REQ_ADDR  in  MEM_ADDR_WIDTH: byte address.
REQ-011 REQ_WDATA  in  MEM_WORD_WIDTH: store data, right-justified.
REQ-012 RSP_VALID  out  1: one-cycle response pulse; no backpressure.
REQ-013 RSP_RDATA  out  MEM_WORD_WIDTH: extended load data; 0 for stores and errors.
REQ-014 RSP_ERR  out  1: access fault (misaligned, illegal size, or memory ADDR_ERR).
REQ-015 RD_M_CLK, RD_ENABLE  out  1 each; RD_WORD  out  2; RD_ADDR  out  MEM_ADDR_WIDTH: drive the mem_read ext_read_port.
REQ-016 RD_DATAIN  in  MEM_WORD_WIDTH; RD_ADDR_ERR  in  1: returned from the mem_read ext_read_port.
REQ-017 WR_M_CLK, WR_ENABLE  out  1 each; WR_WORD  out  2; WR_ADDR  out  MEM_ADDR_WIDTH; WR_DATAOUT  out  MEM_WORD_WIDTH: drive the mem_write ext_write_port.
REQ-018 WR_ADDR_ERR  in  1: returned from the mem_write ext_write_port.

Function
REQ-019 RD_M_CLK and WR_M_CLK SHALL equal CLK combinationally.
REQ-020 The FSM SHALL have four states: IDLE, ISSUE, CAPTURE, RESP.
REQ-021 REQ_READY SHALL be 1 only in IDLE; a request is accepted on the edge where REQ_VALID and REQ_READY are both 1.
REQ-022 On accept, the unit SHALL register WE, SIZE, UNSIGNED, ADDR and WDATA.
- Legal access: IDLE->ISSUE.
- Fault (SIZE=11, half with ADDR[0]=1, word with ADDR[1:0]!=0): IDLE->RESP with the error flag set and no ENABLE asserted.
REQ-023 ISSUE SHALL last exactly one cycle.
- Load: RD_ENABLE=1.
- Store: WR_ENABLE=1.
- In both cases *_ADDR and *_WORD carry the registered values; the other port's ENABLE stays 0. Next state: CAPTURE.
REQ-024 CAPTURE SHALL last exactly one cycle.
- Sample RD_DATAIN/RD_ADDR_ERR (load) or WR_ADDR_ERR (store).
- Next state: RESP.
REQ-025 RESP SHALL assert RSP_VALID for exactly one cycle, then go to IDLE; back-to-back requests are separated by at least one IDLE cycle.
REQ-026 Latency: request accepted at edge N; ENABLE high during cycle N+1; RSP_VALID high during cycle N+3. A faulting request gives RSP_VALID during cycle N+1.
REQ-027 Load extension: byte uses bit 7 and half uses bit 15 of the sampled data, sign- or zero-extended per UNSIGNED; word is passed unchanged.
REQ-028 WR_DATAOUT SHALL be REQ_WDATA masked to the access size (upper bits zero).
REQ-029 If the sampled ADDR_ERR is 1, RSP_ERR SHALL be 1 and RSP_RDATA SHALL be 0.
REQ-030 RD_ADDR/WR_ADDR/WR_DATAOUT/*_WORD SHALL hold their last values when ENABLE=0; only ENABLE qualifies them.
REQ-031 REQ_VALID outside IDLE SHALL be ignored (not queued).

Reset
REQ-032 When RSTn=0 at a CLK edge, the FSM SHALL go to IDLE regardless of state, and the in-flight access is dropped without a response.
REQ-033 Reset values: REQ_READY=1 after reset release; RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0, RD_ENABLE=0, WR_ENABLE=0, *_WORD=0, *_ADDR=0, WR_DATAOUT=0.
REQ-034 RSTn asserted during ISSUE SHALL force RD_ENABLE/WR_ENABLE to 0 from the next cycle.

Verification
REQ-035 Load byte, ADDR=0x13, UNSIGNED=0, RD_DATAIN=0x0000_0080 -> RD_ENABLE pulse at N+1, RSP_VALID at N+3, RSP_RDATA=0xFFFF_FF80, RSP_ERR=0.
REQ-036 Load half unsigned, ADDR=0x22, RD_DATAIN=0x1234_8001 -> RSP_RDATA=0x0000_8001; load word ADDR=0x40 returns RD_DATAIN unchanged.
REQ-037 Store byte, ADDR=0x05, WDATA=0xDEAD_BEEF -> WR_ENABLE pulse at N+1, WR_WORD=00, WR_DATAOUT=0x0000_00EF, RSP_VALID at N+3 with RSP_ERR=0.
REQ-038 Word load at ADDR=0x02 and SIZE=11 -> no ENABLE, RSP_VALID at N+1, RSP_ERR=1, RSP_RDATA=0.
REQ-039 Load with RD_ADDR_ERR=1 during CAPTURE -> RSP_ERR=1, RSP_RDATA=0.
REQ-040 RSTn=0 during CAPTURE -> no RSP_VALID, outputs at reset values, REQ_READY=1 after release; REQ_VALID held high in ISSUE/CAPTURE/RESP is not accepted.
